// File: rtl/pio_instr_encoder_if.sv
// Decoded-field tuple stream into the PIO instruction encoder (valid/ready handshake).
interface pio_instr_encoder_if;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic [2:0] in_op1;
  logic [4:0] in_op2;
  logic [4:0] in_delay;
  logic [4:0] in_side_set;
  logic       in_side_en;

  modport master (
    output in_valid, in_op, in_op1, in_op2, in_delay, in_side_set, in_side_en,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_op, in_op1, in_op2, in_delay, in_side_set, in_side_en,
    output in_ready
  );
endinterface

// File: rtl/pio_instr_encoder.sv
// Packs decoded PIO fields into 16-bit instruction words and streams them into
// the instruction memory write port over a base/length load session.
module pio_instr_encoder #(
  parameter int unsigned MEM_DEPTH = 32,
  parameter int unsigned ADDR_W    = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [2:0]          sideset_bits,
  input  logic                sideset_enable_bit,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     length,
  pio_instr_encoder_if.slave  in_if,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [15:0]         mem_wdata,
  output logic                busy,
  output logic                done,
  output logic                err_overflow,
  output logic                err_config,
  output logic [ADDR_W-1:0]   err_index
);

  localparam int unsigned LEN_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [2:0]         cfg_bits_q, cfg_bits_d;
  logic               cfg_en_q, cfg_en_d;
  logic               in_ready_q, in_ready_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [15:0]        mem_wdata_q, mem_wdata_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_ovf_q, err_ovf_d;
  logic               err_cfg_q, err_cfg_d;
  logic [ADDR_W-1:0]  err_idx_q, err_idx_d;

  // Field encoding against the configuration latched at session start.
  logic [2:0]  delay_bits_c;
  logic [2:0]  sv_w_c;
  logic [4:0]  delay_mask_c;
  logic [4:0]  sv_mask_c;
  logic [4:0]  side_m_c;
  logic [4:0]  field_c;
  logic        ovf_c;
  logic [15:0] word_c;

  always_comb begin
    delay_bits_c = 3'(3'd5 - cfg_bits_q);
    sv_w_c       = 3'(cfg_bits_q - 3'(cfg_en_q));
    delay_mask_c = 5'(5'h1f >> cfg_bits_q);
    sv_mask_c    = 5'((6'd1 << sv_w_c) - 6'd1);
    side_m_c     = in_if.in_side_set & sv_mask_c;
    field_c      = (cfg_en_q ? {in_if.in_side_en, 4'b0000} : 5'b00000)
                 | 5'(side_m_c << delay_bits_c)
                 | (in_if.in_delay & delay_mask_c);
    ovf_c        = (|(in_if.in_delay & ~delay_mask_c)) | (|(in_if.in_side_set & ~sv_mask_c));
    word_c       = {in_if.in_op, field_c, in_if.in_op1, in_if.in_op2};
  end

  logic cfg_legal_c;
  logic len_legal_c;
  logic accept_c;

  assign cfg_legal_c = (sideset_bits <= 3'd5) && !(sideset_enable_bit && (sideset_bits == 3'd0));
  assign len_legal_c = (length != '0) && (length <= LEN_W'(MEM_DEPTH));
  assign accept_c    = in_if.in_valid && in_ready_q;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    idx_d       = idx_q;
    rem_d       = rem_q;
    cfg_bits_d  = cfg_bits_q;
    cfg_en_d    = cfg_en_q;
    in_ready_d  = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    err_ovf_d   = err_ovf_q;
    err_cfg_d   = err_cfg_q;
    err_idx_d   = err_idx_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_legal_c && len_legal_c) begin
            state_d    = S_LOAD;
            base_d     = base_addr;
            idx_d      = '0;
            rem_d      = length;
            cfg_bits_d = sideset_bits;
            cfg_en_d   = sideset_enable_bit;
            err_ovf_d  = 1'b0;
            err_cfg_d  = 1'b0;
            err_idx_d  = '0;
            busy_d     = 1'b1;
            in_ready_d = 1'b1;
          end else begin
            err_cfg_d = 1'b1;
          end
        end
      end

      S_LOAD: begin
        busy_d = 1'b1;
        if (accept_c) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = ADDR_W'(base_q + idx_q);
          mem_wdata_d = word_c;
          idx_d       = ADDR_W'(idx_q + ADDR_W'(1));
          rem_d       = LEN_W'(rem_q - LEN_W'(1));
          if (ovf_c) begin
            err_ovf_d = 1'b1;
            if (!err_ovf_q) err_idx_d = idx_q;
          end
        end
        in_ready_d = (rem_d != '0);
        // Remaining hits zero while the last write is on the port; finish next.
        if (rem_q == '0) begin
          state_d    = S_DONE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          in_ready_d = 1'b0;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      idx_q       <= '0;
      rem_q       <= '0;
      cfg_bits_q  <= '0;
      cfg_en_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_cfg_q   <= 1'b0;
      err_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      idx_q       <= idx_d;
      rem_q       <= rem_d;
      cfg_bits_q  <= cfg_bits_d;
      cfg_en_q    <= cfg_en_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_ovf_q   <= err_ovf_d;
      err_cfg_q   <= err_cfg_d;
      err_idx_q   <= err_idx_d;
    end
  end

  assign in_if.in_ready = in_ready_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err_overflow   = err_ovf_q;
  assign err_config     = err_cfg_q;
  assign err_index      = err_idx_q;

endmodule

// File: doc/pio_instr_encoder.md
Name: pio_instr_encoder

Overview:
- Inverse of the PIO instruction decode path: takes decoded instruction fields (op, op1, op2, delay, side-set) and packs them into 16-bit PIO instruction words.
- Streams the words into the 32-entry PIO instruction memory through a write port.
- Sits between the host/program loader and the PIO instruction memory.
- Encoding honours the same side-set configuration (sideset_bits, sideset_enable_bit) the decoder uses, so decode(encode(x)) == x for every legal x.

Parameters:
- MEM_DEPTH, 32, instruction memory entries; power of two.
- ADDR_W, 5, log2(MEM_DEPTH).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- sideset_bits  input  3  side-set field width including enable bit; legal 0..5
- sideset_enable_bit  input  1  side-set enable bit present (instr[12])
- start  input  1  one-cycle pulse: begin a load session
- base_addr  input  ADDR_W  first memory address of the session
- length  input  ADDR_W+1  instructions in the session, 1..MEM_DEPTH
- in_valid  input  1  field tuple valid
- in_ready  output  1  encoder can accept a tuple
- in_op  input  3  -> instr[15:13]
- in_op1  input  3  -> instr[7:5]
- in_op2  input  5  -> instr[4:0]
- in_delay  input  5  delay cycles
- in_side_set  input  5  side-set value (right-aligned)
- in_side_en  input  1  side-set enable; used only when sideset_enable_bit=1
- mem_we  output  1  instruction memory write strobe
- mem_addr  output  ADDR_W  write address
- mem_wdata  output  16  encoded instruction
- busy  output  1  session active
- done  output  1  one-cycle pulse after the last write
- err_overflow  output  1  sticky: a field was truncated this session
- err_config  output  1  sticky: illegal side-set configuration at start
- err_index  output  ADDR_W  session index of the first overflowing tuple

Behaviour:
- Reset (async, reset_n low):
  - FSM to IDLE.
  - in_ready, mem_we, busy, done, err_* = 0; mem_addr, mem_wdata, err_index = 0.
- Field encoding:
  - Definitions: delay_bits = 5 - sideset_bits; sv_w = sideset_bits - sideset_enable_bit.
  - Field [12:8] = (sideset_enable_bit ? in_side_en<<4 : 0) | ((in_side_set masked to sv_w bits) << delay_bits) | (in_delay masked to delay_bits bits).
  - Overflow when in_delay >= 2^delay_bits or in_side_set >= 2^sv_w. The masked word is still written; err_overflow is set; err_index latches only on the first overflow in the session.
- Config check at start:
  - Illegal when sideset_bits > 5, or sideset_enable_bit=1 with sideset_bits=0.
  - On illegal config: err_config=1, and the session is refused (stays IDLE, no done pulse).
  - Config inputs are sampled at start and held for the whole session; later changes are ignored.
- FSM IDLE:
  - in_ready=0.
  - On start with legal config and length in 1..MEM_DEPTH: latch base_addr, length, config; clear err_overflow, err_index, err_config; set busy=1; go to LOAD.
  - On start with length 0 or length > MEM_DEPTH: err_config=1, stay IDLE.
- FSM LOAD:
  - in_ready=1 while remaining > 0.
  - Handshake is in_valid && in_ready.
  - Each accepted tuple: registered write one cycle later. mem_we=1, mem_addr = base + index (mod MEM_DEPTH, wraps 31->0), mem_wdata = encoded word.
  - Throughput one tuple per cycle; latency accept -> mem_we is exactly 1 cycle.
  - in_ready drops in the cycle after the last tuple is accepted.
  - After the last write: go to DONE.
- FSM DONE:
  - done=1 for one cycle; busy=0; return to IDLE.
- start while busy is ignored.
- Reset mid-session:
  - The session is discarded and no further writes occur.
  - Already-written words stay in memory.
- mem_we is never asserted outside LOAD/DONE.

Test Plan:
- Config sideset_bits=0, en=0; start base=0 len=1; tuple op=3'b101 op1=3'b010 op2=5'h11 delay=5'd7 -> one cycle after handshake: mem_we=1, addr=0, wdata=16'hA751; then done pulse; no errors.
- sideset_bits=3, en=1; tuple side_en=1 side_set=2'b10 delay=3 op=0 op1=0 op2=0 -> wdata=16'h1B00; decoder on that word returns delay=3, side_set=2, sideset_enabled=1.
- sideset_bits=2, en=0; 4 back-to-back tuples, in_valid held high, with tuple 3 delay=5'd9 (limit 7) -> 4 writes on consecutive cycles; tuple 3 wdata field[12:8] delay=1; err_overflow=1; err_index=2.
- base=30 len=4 -> writes to addresses 30, 31, 0, 1; done one cycle after the write to 1.
- start with sideset_bits=6 -> err_config=1, busy stays 0, no mem_we; separately, start with len=0 -> err_config=1.
- reset_n pulsed low after 2 of 5 writes -> all outputs return to 0 immediately; no further mem_we; a new start then works normally.
